// File: rtl/out_port_tx.sv
// Output-port transmitter: latches OUT writes for display, queues them in a small FIFO
// and sends each byte as 8N1 UART on o_tx. A write that finds the FIFO full is dropped.
module out_port_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wrOut,
   input  logic [7:0] i_bus,
   output logic       o_tx,
   output logic [7:0] o_display,
   output logic       o_full,
   output logic       o_busy,
   output logic       o_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          baud_last;
   logic          full;
   logic          pop;
   logic          push;

   // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
   always_comb begin
      baud_last = (baud == BAUD_LAST);
      full      = (count == DEPTH_C);
      pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_last));
      push      = i_wrOut && (!full || pop);
   end

   assign o_full = full;
   assign o_busy = (count != '0) || (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_bus;
      if (pop)
         shift <= mem[rd_ptr];
      else if ((state == DATA) && baud_last)
         shift <= {1'b0, shift[7:1]};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         o_tx       <= 1'b1;
         o_display  <= 8'h00;
         o_overflow <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         baud       <= '0;
         bit_idx    <= '0;
      end else begin
         if (i_wrOut) begin
            o_display <= i_bus;
            if (!push)
               o_overflow <= 1'b1;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;

         case (state)
            IDLE: begin
               o_tx <= 1'b1;
               baud <= '0;
               if (pop) begin
                  state <= START;
                  o_tx  <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  o_tx    <= shift[0];
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     o_tx  <= 1'b1;
                  end else begin
                     // shift moves right on this same edge, so the next bit is shift[1]
                     bit_idx <= bit_idx + 1'b1;
                     o_tx    <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (pop) begin
                     state <= START;
                     o_tx  <= 1'b0;
                  end else begin
                     state <= IDLE;
                     o_tx  <= 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_out_port_tx.sv
// Bench for out_port_tx: frame-level queue model checked every cycle, directed scenarios
// with literal expectations, then randomized writes and resets.
module tb_out_port_tx;
   localparam int C = 4;
   localparam int D = 4;
   localparam int FL = 10 * C;

   logic       i_clk, i_reset, i_wrOut;
   logic [7:0] i_bus;
   logic       o_tx, o_full, o_busy, o_overflow;
   logic [7:0] o_display;

   out_port_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_wrOut(i_wrOut), .i_bus(i_bus),
      .o_tx(o_tx), .o_display(o_display), .o_full(o_full), .o_busy(o_busy),
      .o_overflow(o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Model: pending bytes, plus the frame on the line with its cycle position m_t.
   logic [7:0] m_q[$];
   bit         m_active;
   int         m_t;
   logic [7:0] m_cur;
   bit         m_ovf;
   logic [7:0] m_disp;

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Literal expectations posted by the stimulus thread for the next compare.
   logic [5:0] lit_mask = '0;
   logic       lit_tx, lit_busy, lit_full, lit_ovf, wait_to;
   logic [7:0] lit_disp;

   function automatic logic exp_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_t / C;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_cur[k-1];
   endfunction

   task automatic model_edge(input bit rst, input bit wr, input logic [7:0] d);
      int  pre;
      bit  do_pop;
      if (rst) begin
         m_q.delete();
         m_active = 0; m_t = 0; m_ovf = 0; m_disp = 8'h00;
         return;
      end
      pre    = m_q.size();
      do_pop = (pre > 0) && (!m_active || m_t == FL - 1);
      if (m_active) begin
         if (m_t == FL - 1) begin
            if (do_pop) begin m_cur = m_q.pop_front(); m_t = 0; end
            else m_active = 0;
         end else m_t++;
      end else if (do_pop) begin
         m_cur = m_q.pop_front(); m_active = 1; m_t = 0;
      end
      if (wr) begin
         m_disp = d;
         if (m_q.size() < D) m_q.push_back(d);
         else m_ovf = 1;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      if (chk_en) begin
         check("tx", {7'b0, o_tx}, {7'b0, exp_tx()});
         check("display", o_display, m_disp);
         check("full", {7'b0, o_full}, {7'b0, m_q.size() == D});
         check("busy", {7'b0, o_busy}, {7'b0, (m_q.size() > 0) || m_active});
         check("overflow", {7'b0, o_overflow}, {7'b0, m_ovf});
         if (lit_mask[0]) check("lit_tx", {7'b0, o_tx}, {7'b0, lit_tx});
         if (lit_mask[1]) check("lit_busy", {7'b0, o_busy}, {7'b0, lit_busy});
         if (lit_mask[2]) check("lit_full", {7'b0, o_full}, {7'b0, lit_full});
         if (lit_mask[3]) check("lit_overflow", {7'b0, o_overflow}, {7'b0, lit_ovf});
         if (lit_mask[4]) check("lit_display", o_display, lit_disp);
         if (lit_mask[5]) check("wait_bound", {7'b0, wait_to}, 8'h00);
      end
   end

   task automatic cycle(input bit rst, input bit wr, input logic [7:0] d);
      i_reset = rst; i_wrOut = wr; i_bus = d;
      @(posedge i_clk);
      model_edge(rst, wr, d);
      lit_mask = '0;
      chk_en   = 1;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
   endtask

   task automatic exp_tx_lit(input logic v);   lit_tx = v;   lit_mask[0] = 1; endtask
   task automatic exp_busy_lit(input logic v); lit_busy = v; lit_mask[1] = 1; endtask
   task automatic exp_full_lit(input logic v); lit_full = v; lit_mask[2] = 1; endtask
   task automatic exp_ovf_lit(input logic v);  lit_ovf = v;  lit_mask[3] = 1; endtask
   task automatic exp_disp_lit(input logic [7:0] v); lit_disp = v; lit_mask[4] = 1; endtask

   int frame_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   initial begin
      int n;
      i_reset = 1; i_wrOut = 0; i_bus = 8'h00;

      // reset
      cycle(1, 0, 8'h00);
      cycle(1, 0, 8'h00);
      exp_tx_lit(1); exp_busy_lit(0); exp_full_lit(0); exp_ovf_lit(0); exp_disp_lit(8'h00);
      idle(2);

      // single byte 0xA5
      cycle(0, 1, 8'hA5);
      exp_disp_lit(8'hA5); exp_busy_lit(1);
      for (int j = 0; j < FL; j++) begin
         idle(1);
         exp_tx_lit(frame_a5[j / C][0]);
      end
      idle(1);
      exp_busy_lit(0); exp_tx_lit(1);
      idle(3);

      // burst of five while idle
      for (int b = 1; b <= 5; b++) cycle(0, 1, 8'(b));
      exp_full_lit(1); exp_ovf_lit(0);
      idle(5 * FL + 10);
      exp_busy_lit(0);

      // overflow during a frame
      cycle(0, 1, 8'h10);
      idle(2);
      for (int b = 0; b < 4; b++) cycle(0, 1, 8'h11 + 8'(b));
      exp_full_lit(1);
      cycle(0, 1, 8'h77);
      exp_ovf_lit(1); exp_disp_lit(8'h77); exp_full_lit(1);
      idle(5 * FL + 20);
      exp_ovf_lit(1); exp_busy_lit(0);

      // write while full on the STOP-last edge
      cycle(1, 0, 8'h00);
      cycle(1, 0, 8'h00);
      exp_ovf_lit(0);
      cycle(0, 1, 8'h20);
      idle(1);
      for (int b = 1; b <= 4; b++) cycle(0, 1, 8'h20 + 8'(b));
      n = 0;
      while (!(m_active && m_t == FL - 1 && m_q.size() == D) && n < 200) begin idle(1); n++; end
      wait_to = (n >= 200); lit_mask[5] = 1;
      cycle(0, 1, 8'h25);
      exp_full_lit(1); exp_ovf_lit(0); exp_disp_lit(8'h25);
      idle(5 * FL + 20);
      exp_busy_lit(0); exp_ovf_lit(0);

      // reset in the middle of data bit 3
      cycle(0, 1, 8'h5A);
      cycle(0, 1, 8'h3C);
      n = 0;
      while (!(m_active && m_t / C == 4) && n < 200) begin idle(1); n++; end
      wait_to = (n >= 200); lit_mask[5] = 1;
      cycle(1, 0, 8'h00);
      exp_tx_lit(1); exp_busy_lit(0); exp_full_lit(0);
      for (int j = 0; j < FL + 5; j++) begin
         idle(1);
         exp_tx_lit(1); exp_busy_lit(0);
      end

      // randomized writes with rare resets
      for (int i = 0; i < 3000; i++) begin
         bit rst, wr;
         rst = ($urandom_range(0, 599) == 0);
         wr  = ($urandom_range(0, 99) < ((i < 1500) ? 5 : 40));
         cycle(rst, wr, 8'($urandom));
      end
      idle(6 * FL);

      @(negedge i_clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
